key_event_arbiter: RTL and testbench
====================================

# key_event_arbiter

Front-end controller that turns the four raw push-button inputs into a serialized stream of key-press events for the downstream key-sequence state machine that drives HEX0. It synchronizes and debounces each key and detects press edges. Simultaneous presses are arbitrated round-robin, and grants are queued in a small FIFO. Events are delivered one at a time over a valid/ready handshake, so the consumer FSM never sees two keys in one cycle or misses a press while busy.

## Interface
- DEBOUNCE_CYCLES, 1: consecutive cycles a synchronized key must differ from its debounced level before the level flips; legal 1..255.
- FIFO_DEPTH, 4: event queue entries; power of two, 2..16.
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- KEY  in  4  raw buttons, asynchronous to CLOCK_50, high = pressed.
- EVT_READY  in  1  consumer accepts the head event this cycle.
- CLR_OVF  in  1  synchronous clear of OVERFLOW.
- EVT_VALID  out  1  head event available.
- EVT_KEY  out  2  index (0..3) of the key in the head event.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  events queued.
- OVERFLOW  out  1  sticky: a press was dropped.

## Operation
- Reset (RESET_N low, asynchronous): synchronizers, debounced levels, debounce counters, pending flags, FIFO pointers and round-robin pointer cleared. All outputs are 0: EVT_VALID=0, EVT_KEY=0, FIFO_COUNT=0, OVERFLOW=0. The round-robin pointer reset value is "last grant = 3", so key 0 has first priority.
- Synchronizer: 2-flop per KEY bit.
- Debounce, per key:
  - The counter clears whenever the synchronized value equals the debounced level.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while the values still differ, the debounced level takes the synchronized value and the counter clears.
- Press event: a 0->1 transition of a debounced level sets that key's pending flag. Releases generate nothing.
- Pending collision: a press on a key whose pending flag is already set is dropped and sets OVERFLOW. The flag stays set, so there is one pending event per key.
- Arbiter: each cycle, if any flag is pending and the FIFO can accept, it grants exactly one key.
  - The winner is the first pending index after the last granted index, wrapping modulo 4.
  - The winner's flag clears, its index is written to the FIFO, and the pointer moves to the winner.
- FIFO can accept when FIFO_COUNT < FIFO_DEPTH, or when FIFO_COUNT == FIFO_DEPTH and a pop occurs in the same cycle.
- A full FIFO backpressures the arbiter: flags are held, not dropped.
- Output: EVT_VALID = (FIFO_COUNT != 0). EVT_KEY = head entry, held stable while EVT_VALID && !EVT_READY.
- Pop occurs when EVT_VALID && EVT_READY. EVT_READY is ignored when EVT_VALID=0.
- FIFO_COUNT changes per cycle as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Pointers wrap modulo FIFO_DEPTH.
- OVERFLOW: set by a drop and cleared by CLR_OVF. A drop in the same cycle as CLR_OVF takes precedence (OVERFLOW=1).
- Key held through reset release: the debounced level starts at 0, so exactly one press event is produced after debounce.

## Timing
- E0 is the first rising edge that samples KEY[i]=1, and the key stays high long enough. Then:
  - sync output is 1 after E0+1;
  - debounced level is 1 after E0+1+DEBOUNCE_CYCLES;
  - pending flag is set after E0+2+DEBOUNCE_CYCLES;
  - FIFO write occurs, so EVT_VALID=1 and EVT_KEY=i, after E0+3+DEBOUNCE_CYCLES, provided the FIFO was empty and no other key was pending.
- The minimum accepted press width is DEBOUNCE_CYCLES cycles. With the default of 1, a one-cycle pulse registers.
- Throughput: one grant per cycle and one pop per cycle. N simultaneous presses reach the FIFO in N consecutive cycles.
- Pop-to-next-head: combinational from the FIFO read pointer. The next EVT_KEY is valid in the cycle after the pop edge.
- An asynchronous reset assertion mid-operation discards all queued and pending events immediately. There is no partial output.

## Test plan
- Single press, DEBOUNCE_CYCLES=1, EVT_READY=1: pulse KEY[3] high for 1 cycle -> EVT_VALID high for exactly 1 cycle, 4 edges after E0, EVT_KEY=3, FIFO_COUNT 1->0.
- Debounce, DEBOUNCE_CYCLES=3:
  - 2-cycle pulse on KEY[1] -> no event.
  - 3-cycle pulse on KEY[1] -> one event with EVT_KEY=1.
  - Release -> no event.
- Simultaneous press with KEY=4'b1111 for 1 cycle and EVT_READY=1, after a prior grant of key 1 -> EVT_KEY sequence 2,3,0,1 on consecutive cycles, OVERFLOW=0.
- Backpressure with FIFO_DEPTH=4 and EVT_READY=0:
  - Press keys 0,1,2,3,0 sequentially -> FIFO_COUNT=4, key 0 held pending.
  - A further key-0 press -> OVERFLOW=1.
  - Raise EVT_READY -> events 0,1,2,3,0 delivered in order, FIFO_COUNT reaches 0.
- Reset mid-operation: with 3 events queued, pull RESET_N low between edges -> EVT_VALID, FIFO_COUNT and OVERFLOW read 0 immediately. KEY[2] held high through release -> exactly one event with EVT_KEY=2 after debounce.

Source files
------------

// File: rtl/key_event_arbiter_if.sv
// Event-stream handshake between the key front-end and its consumer FSM.
// The master side produces events; the slave side consumes them and clears OVERFLOW.
interface key_event_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          EVT_VALID;
  logic          EVT_READY;
  logic [1:0]    EVT_KEY;
  logic [CW-1:0] FIFO_COUNT;
  logic          OVERFLOW;
  logic          CLR_OVF;

  modport master (
    input  EVT_READY, CLR_OVF,
    output EVT_VALID, EVT_KEY, FIFO_COUNT, OVERFLOW
  );

  modport slave (
    output EVT_READY, CLR_OVF,
    input  EVT_VALID, EVT_KEY, FIFO_COUNT, OVERFLOW
  );
endinterface

// File: rtl/key_event_arbiter.sv
// Push-button front end: sync, debounce, press detect, round-robin arbitration
// and an event FIFO delivering one key index at a time over valid/ready.
module key_event_arbiter #(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [3:0]          KEY,
  key_event_arbiter_if.master evt
);
  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam int         CW      = AW + 1;
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1, sync2;
  logic [3:0]    level, level_q;
  logic [7:0]    db_cnt [4];
  logic [3:0]    pending, press, grant_mask, pending_next;
  logic [1:0]    last_grant, grant_idx, cand;
  logic          grant_valid, drop, pop, can_push, overflow;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  // level_q lags level by one cycle so a press is seen the cycle after the flip
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      level   <= '0;
      level_q <= '0;
      for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      level_q <= level;
      for (int k = 0; k < 4; k++) begin
        if (sync2[k] == level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          level[k]  <= sync2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + 8'd1;
        end
      end
    end
  end

  assign press    = level & ~level_q;
  assign pop      = (count != '0) && evt.EVT_READY;
  assign can_push = (count < CW'(FIFO_DEPTH)) || pop;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    if (can_push) begin
      for (int j = 1; j <= 4; j++) begin
        cand = last_grant + 2'(j);
        if (!grant_valid && pending[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // A press only collides when its flag survives this cycle's grant
  assign grant_mask   = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
  assign drop         = |(press & pending & ~grant_mask);
  assign pending_next = (pending & ~grant_mask) | press;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pending    <= '0;
      last_grant <= 2'd3;
      overflow   <= 1'b0;
    end else begin
      pending <= pending_next;
      if (grant_valid) last_grant <= grant_idx;
      if (drop) overflow <= 1'b1;
      else if (evt.CLR_OVF) overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({grant_valid, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (grant_valid) mem[wr_ptr] <= grant_idx;
  end

  assign evt.EVT_VALID  = (count != '0);
  assign evt.EVT_KEY    = (count != '0) ? mem[rd_ptr] : 2'd0;
  assign evt.FIFO_COUNT = count;
  assign evt.OVERFLOW   = overflow;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: two instances (debounce 1 and 3) share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_key_event_arbiter;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'b0;
  logic       ready = 1'b0;
  logic       clr = 1'b0;

  int errors = 0;
  int checks = 0;
  int code_a = 0;
  int code_b = 0;
  int valid_cycles_a = 0;

  key_event_arbiter_if #(.FIFO_DEPTH(DEPTH)) if_a ();
  key_event_arbiter_if #(.FIFO_DEPTH(DEPTH)) if_b ();

  assign if_a.EVT_READY = ready;
  assign if_a.CLR_OVF   = clr;
  assign if_b.EVT_READY = ready;
  assign if_b.CLR_OVF   = clr;

  key_event_arbiter #(.DEBOUNCE_CYCLES(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .evt(if_a.master)
  );
  key_event_arbiter #(.DEBOUNCE_CYCLES(3), .FIFO_DEPTH(DEPTH)) dut_b (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .evt(if_b.master)
  );

  always #5 clk = ~clk;

  logic [3:0] m_s1 [2];
  logic [3:0] m_s2 [2];
  logic [3:0] m_lvl [2];
  logic [3:0] m_lvlq [2];
  logic [3:0] m_pend [2];
  int         m_cnt [2][4];
  int         m_last [2];
  bit         m_ovf [2];
  int         mq_a [$];
  int         mq_b [$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_lvlq[i] = 0; m_pend[i] = 0;
      m_last[i] = 3; m_ovf[i] = 0;
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
    end
    mq_a.delete();
    mq_b.delete();
  endtask

  // One clock of the reference behaviour, computed from the pre-edge state
  task automatic model_step(int i, int db);
    int q [$];
    logic [3:0] press;
    bit gv, drop, pop;
    int gidx, idx;
    if (i == 0) q = mq_a; else q = mq_b;
    pop = (q.size() != 0) && ready;
    gv = 0; gidx = 0;
    if (q.size() < DEPTH || pop) begin
      for (int j = 1; j <= 4; j++) begin
        idx = (m_last[i] + j) % 4;
        if (!gv && m_pend[i][idx]) begin gv = 1; gidx = idx; end
      end
    end
    press = m_lvl[i] & ~m_lvlq[i];
    drop = 0;
    for (int k = 0; k < 4; k++) begin
      if (press[k]) begin
        if (m_pend[i][k] && !(gv && gidx == k)) drop = 1;
        m_pend[i][k] = 1'b1;
      end else if (gv && gidx == k) begin
        m_pend[i][k] = 1'b0;
      end
    end
    if (drop) m_ovf[i] = 1;
    else if (clr) m_ovf[i] = 0;
    if (pop) void'(q.pop_front());
    if (gv) begin q.push_back(gidx); m_last[i] = gidx; end
    m_lvlq[i] = m_lvl[i];
    for (int k = 0; k < 4; k++) begin
      if (m_s2[i][k] == m_lvl[i][k]) m_cnt[i][k] = 0;
      else if (m_cnt[i][k] == db - 1) begin m_lvl[i][k] = m_s2[i][k]; m_cnt[i][k] = 0; end
      else m_cnt[i][k]++;
    end
    m_s2[i] = m_s1[i];
    m_s1[i] = key;
    if (i == 0) mq_a = q; else mq_b = q;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, 1);
      model_step(1, 3);
    end
  end

  task automatic checkOutput(string tag, int observed, int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compare_all();
    checkOutput("valid_a", int'(if_a.EVT_VALID), int'(mq_a.size() != 0));
    checkOutput("key_a", int'(if_a.EVT_KEY), (mq_a.size() != 0) ? mq_a[0] : 0);
    checkOutput("count_a", int'(if_a.FIFO_COUNT), mq_a.size());
    checkOutput("ovf_a", int'(if_a.OVERFLOW), int'(m_ovf[0]));
    checkOutput("valid_b", int'(if_b.EVT_VALID), int'(mq_b.size() != 0));
    checkOutput("key_b", int'(if_b.EVT_KEY), (mq_b.size() != 0) ? mq_b[0] : 0);
    checkOutput("count_b", int'(if_b.FIFO_COUNT), mq_b.size());
    checkOutput("ovf_b", int'(if_b.OVERFLOW), int'(m_ovf[1]));
  endtask

  // Outputs are compared at the falling edge, then inputs for the next edge are driven
  task automatic applyStimulus(logic [3:0] k, logic r, logic c);
    @(negedge clk);
    compare_all();
    key = k; ready = r; clr = c;
    if (if_a.EVT_VALID) valid_cycles_a++;
    if (if_a.EVT_VALID && ready) code_a = code_a * 5 + int'(if_a.EVT_KEY) + 1;
    if (if_b.EVT_VALID && ready) code_b = code_b * 5 + int'(if_b.EVT_KEY) + 1;
  endtask

  task automatic press_key(logic [3:0] k, int width, int gap, logic r);
    for (int n = 0; n < width; n++) applyStimulus(k, r, 1'b0);
    for (int n = 0; n < gap; n++) applyStimulus(4'b0, r, 1'b0);
  endtask

  task automatic clear_logs();
    code_a = 0; code_b = 0; valid_cycles_a = 0;
  endtask

  initial begin
    logic [3:0] rk;
    for (int n = 0; n < 3; n++) applyStimulus(4'b0, 1'b0, 1'b0);
    checkOutput("reset_count_a", int'(if_a.FIFO_COUNT), 0);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) applyStimulus(4'b0, 1'b1, 1'b0);

    $display("[TB] single one-cycle press of key 3");
    clear_logs();
    press_key(4'b1000, 1, 15, 1'b1);
    checkOutput("single_seq_a", code_a, 4);
    checkOutput("single_valid_cycles_a", valid_cycles_a, 1);
    checkOutput("single_seq_b", code_b, 0);

    $display("[TB] debounce pulse widths on key 1");
    clear_logs();
    press_key(4'b0010, 2, 15, 1'b1);
    checkOutput("db2_seq_a", code_a, 2);
    checkOutput("db2_seq_b", code_b, 0);
    clear_logs();
    press_key(4'b0010, 3, 15, 1'b1);
    checkOutput("db3_seq_a", code_a, 2);
    checkOutput("db3_seq_b", code_b, 2);

    $display("[TB] simultaneous press after grant of key 1");
    clear_logs();
    press_key(4'b1111, 3, 15, 1'b1);
    checkOutput("rr_seq_a", code_a, 482);
    checkOutput("rr_seq_b", code_b, 482);
    checkOutput("rr_ovf_a", int'(if_a.OVERFLOW), 0);

    $display("[TB] backpressure with consumer stalled");
    clear_logs();
    press_key(4'b0001, 3, 6, 1'b0);
    press_key(4'b0010, 3, 6, 1'b0);
    press_key(4'b0100, 3, 6, 1'b0);
    press_key(4'b1000, 3, 6, 1'b0);
    press_key(4'b0001, 3, 8, 1'b0);
    checkOutput("bp_full_a", int'(if_a.FIFO_COUNT), 4);
    checkOutput("bp_ovf_before_b", int'(if_b.OVERFLOW), 0);
    press_key(4'b0001, 3, 8, 1'b0);
    checkOutput("bp_ovf_a", int'(if_a.OVERFLOW), 1);
    checkOutput("bp_ovf_b", int'(if_b.OVERFLOW), 1);
    press_key(4'b0000, 0, 12, 1'b1);
    checkOutput("bp_seq_a", code_a, 971);
    checkOutput("bp_seq_b", code_b, 971);
    checkOutput("bp_drained_b", int'(if_b.FIFO_COUNT), 0);
    applyStimulus(4'b0, 1'b1, 1'b1);
    applyStimulus(4'b0, 1'b1, 1'b0);
    checkOutput("clr_ovf_a", int'(if_a.OVERFLOW), 0);

    $display("[TB] asynchronous reset with events queued");
    clear_logs();
    press_key(4'b0001, 3, 6, 1'b0);
    press_key(4'b0010, 3, 6, 1'b0);
    press_key(4'b0100, 3, 10, 1'b0);
    checkOutput("pre_rst_count_a", int'(if_a.FIFO_COUNT), 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    key = 4'b0100;
    #1;
    checkOutput("rst_valid_a", int'(if_a.EVT_VALID), 0);
    checkOutput("rst_count_a", int'(if_a.FIFO_COUNT), 0);
    checkOutput("rst_valid_b", int'(if_b.EVT_VALID), 0);
    checkOutput("rst_count_b", int'(if_b.FIFO_COUNT), 0);
    checkOutput("rst_ovf_b", int'(if_b.OVERFLOW), 0);
    for (int n = 0; n < 2; n++) applyStimulus(4'b0100, 1'b1, 1'b0);
    rst_n = 1'b1;
    press_key(4'b0100, 12, 15, 1'b1);
    checkOutput("held_seq_a", code_a, 3);
    checkOutput("held_seq_b", code_b, 3);

    $display("[TB] randomized traffic");
    rk = 4'b0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) rk[b] = ~rk[b];
      applyStimulus(rk, 1'($urandom_range(1)), 1'($urandom_range(15) == 0));
    end
    press_key(4'b0, 0, 20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
